// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampling, 2-of-3 vote) feeding a byte FIFO read over the peripheral bus.
// Byte visible one cycle after the stop decision; bus acks one cycle after request; a full FIFO drops bytes and sets OVR.
module uart_rx_fifo #(
    parameter int CLOCK_RATE = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic        i_rw,
    input  logic        i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_rx_irq,
    input  logic        UART_RX
);
    localparam int DIV = CLOCK_RATE / (BAUD_RATE * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] TICK_ONE = DW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;

    logic          rx_meta, rx_s;
    logic [DW-1:0] tick_cnt;
    logic          tick;
    state_t        state, state_nxt;
    logic [3:0]    sc;
    logic          smp7, smp8, maj;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push_rx, ferr_evt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, pop, push_ok, ovr_set;
    logic          ovr, ferr, acked, start, clr_ovr, clr_ferr;
    logic [8:0]    cnt9;
    logic [31:0]   status, rd_val;
    logic          unused_wdata;

    assign unused_wdata = ^{i_wdata[31:4], i_wdata[1:0]};

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (tick_cnt == DIV_LAST);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)  tick_cnt <= '0;
        else if (tick)   tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + TICK_ONE;
    end

    // The sc=9 sample is taken live so the vote resolves on the same tick.
    assign maj = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push_rx   = 1'b0;
        ferr_evt  = 1'b0;
        if (tick) begin
            case (state)
                S_IDLE:      if (!rx_s) state_nxt = S_START;
                S_START: begin
                    if (sc == 4'd9 && maj) state_nxt = S_IDLE;
                    else if (sc == 4'd15)  state_nxt = S_DATA;
                end
                S_DATA:      if (sc == 4'd15 && bit_idx == 3'd7) state_nxt = S_STOP;
                S_STOP: begin
                    if (sc == 4'd9) begin
                        if (maj) begin
                            push_rx   = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            ferr_evt  = 1'b1;
                            state_nxt = S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: if (rx_s) state_nxt = S_IDLE;
                default:     state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sc      <= '0;
            smp7    <= 1'b1;
            smp8    <= 1'b1;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (tick) begin
            sc <= (state == S_IDLE) ? 4'd0 : sc + 4'd1;
            if (sc == 4'd7) smp7 <= rx_s;
            if (sc == 4'd8) smp8 <= rx_s;
            if (state == S_START) bit_idx <= '0;
            if (state == S_DATA && sc == 4'd9)  shreg   <= {maj, shreg[7:1]};
            if (state == S_DATA && sc == 4'd15) bit_idx <= bit_idx + 3'd1;
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign start    = i_enable & ~acked;
    assign pop      = start & ~i_rw & ~i_address & ~empty;
    assign push_ok  = push_rx & (~full | pop);
    assign ovr_set  = push_rx & full & ~pop;
    assign clr_ovr  = start & i_rw & i_address & i_wdata[2];
    assign clr_ferr = start & i_rw & i_address & i_wdata[3];
    assign o_rx_irq = ~empty;

    always_ff @(posedge i_clock) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop)      count <= count + CNT_ONE;
            else if (!push_ok && pop) count <= count - CNT_ONE;
            if (ovr_set)       ovr <= 1'b1;
            else if (clr_ovr)  ovr <= 1'b0;
            if (ferr_evt)      ferr <= 1'b1;
            else if (clr_ferr) ferr <= 1'b0;
        end
    end

    assign cnt9   = 9'(count);
    assign status = {15'b0, cnt9, 4'b0, ferr, ovr, full, ~empty};

    always_comb begin
        rd_val = '0;
        if (!i_rw) begin
            if (i_address)   rd_val = status;
            else if (!empty) rd_val = {24'b0, mem[rd_ptr]};
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acked   <= 1'b0;
            o_ready <= 1'b0;
            o_rdata <= '0;
        end else if (!i_enable) begin
            acked   <= 1'b0;
            o_ready <= 1'b0;
        end else if (!acked) begin
            acked   <= 1'b1;
            o_ready <= 1'b1;
            o_rdata <= rd_val;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 160 clocks per bit.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int BITC  = 160;
    localparam int NSTR  = 20;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, rw = 1'b0, addr = 1'b0, rx = 1'b1;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready, irq;

    int checks = 0, failures = 0, cyc = 0;
    logic [7:0] exp_q[$];
    logic exp_ovr = 1'b0, exp_ferr = 1'b0;

    uart_rx_fifo #(.CLOCK_RATE(1600000), .BAUD_RATE(10000), .FIFO_DEPTH(DEPTH)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_rw(rw), .i_address(addr),
        .i_wdata(wdata), .o_rdata(rdata), .o_ready(ready), .o_rx_irq(irq), .UART_RX(rx));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_status();
        logic [8:0] n;
        n = 9'(exp_q.size());
        return {15'b0, n, 4'b0, exp_ferr, exp_ovr, (exp_q.size() == DEPTH), (exp_q.size() != 0)};
    endfunction

    task automatic bus(input logic w, input logic a, input logic [31:0] wd, input int hold,
                       output logic [31:0] rd);
        int n;
        en = 1'b1; rw = w; addr = a; wdata = wd; n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 8);
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL bus_ready actual=%0b required=1", ready);
        end
        repeat (hold) @(negedge clk);
        rd = rdata;
        en = 1'b0; rw = 1'b0; addr = 1'b0; wdata = '0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0; repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i]; repeat (BITC) @(negedge clk);
        end
        rx = stop; repeat (BITC) @(negedge clk);
    endtask

    task automatic send_expect(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr = 1'b1;
        send_frame(b, 1'b1);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata actual=%h required=0", rdata); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready actual=%b required=0", ready); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq actual=%b required=0", irq); end
        bus(1'b0, 1'b1, '0, 0, rd);
        checks++; if (rd !== exp_status()) begin failures++; $display("FAIL reset_status actual=%h required=%h", rd, exp_status()); end
    endtask

    task automatic test_single();
        logic [31:0] rd, ex;
        send_expect(8'hA5);
        repeat (20) @(negedge clk);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL single_irq actual=%b required=1", irq); end
        bus(1'b0, 1'b1, '0, 0, rd);
        checks++; if (rd !== 32'h101) begin failures++; $display("FAIL single_status actual=%h required=101", rd); end
        bus(1'b0, 1'b0, '0, 0, rd);
        ex = {24'b0, exp_q.pop_front()};
        checks++; if (rd !== ex) begin failures++; $display("FAIL single_data actual=%h required=%h", rd, ex); end
        bus(1'b0, 1'b1, '0, 0, rd);
        checks++; if (rd !== exp_status()) begin failures++; $display("FAIL single_status_after actual=%h required=%h", rd, exp_status()); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_after actual=%b required=0", irq); end
    endtask

    task automatic test_glitch();
        logic [31:0] rd;
        rx = 1'b0; repeat (30) @(negedge clk);
        rx = 1'b1; repeat (2 * BITC) @(negedge clk);
        bus(1'b0, 1'b1, '0, 0, rd);
        checks++; if (rd !== exp_status()) begin failures++; $display("FAIL glitch_status actual=%h required=%h", rd, exp_status()); end
    endtask

    task automatic test_ferr();
        logic [31:0] rd, ex;
        send_frame(8'h3C, 1'b0);
        repeat (BITC) @(negedge clk);
        rx = 1'b1; exp_ferr = 1'b1;
        repeat (2 * BITC) @(negedge clk);
        bus(1'b0, 1'b1, '0, 0, rd);
        checks++; if (rd !== exp_status()) begin failures++; $display("FAIL ferr_status actual=%h required=%h", rd, exp_status()); end
        bus(1'b1, 1'b1, 32'h8, 0, rd);
        exp_ferr = 1'b0;
        bus(1'b0, 1'b1, '0, 0, rd);
        checks++; if (rd !== exp_status()) begin failures++; $display("FAIL ferr_clear actual=%h required=%h", rd, exp_status()); end
        send_expect(8'h55);
        repeat (20) @(negedge clk);
        bus(1'b0, 1'b0, '0, 0, rd);
        ex = {24'b0, exp_q.pop_front()};
        checks++; if (rd !== ex) begin failures++; $display("FAIL ferr_next_data actual=%h required=%h", rd, ex); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, ex;
        for (int i = 0; i <= DEPTH; i++) send_expect(8'(i));
        repeat (20) @(negedge clk);
        bus(1'b0, 1'b1, '0, 0, rd);
        checks++; if (rd !== exp_status()) begin failures++; $display("FAIL ovf_status actual=%h required=%h", rd, exp_status()); end
        // First read holds the request to confirm a single pop per transaction.
        bus(1'b0, 1'b0, '0, 3, rd);
        ex = {24'b0, exp_q.pop_front()};
        checks++; if (rd !== ex) begin failures++; $display("FAIL ovf_hold_data actual=%h required=%h", rd, ex); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ovf_ready_drop actual=%b required=0", ready); end
        for (int i = 1; i < DEPTH; i++) begin
            bus(1'b0, 1'b0, '0, 0, rd);
            ex = {24'b0, exp_q.pop_front()};
            checks++; if (rd !== ex) begin failures++; $display("FAIL ovf_data%0d actual=%h required=%h", i, rd, ex); end
        end
        bus(1'b0, 1'b0, '0, 0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL ovf_empty_read actual=%h required=0", rd); end
        bus(1'b1, 1'b1, 32'h4, 0, rd);
        exp_ovr = 1'b0;
        bus(1'b0, 1'b1, '0, 0, rd);
        checks++; if (rd !== exp_status()) begin failures++; $display("FAIL ovf_clear actual=%h required=%h", rd, exp_status()); end
    endtask

    task automatic test_stream();
        logic [31:0] rd, ex;
        int base, n;
        fork
            begin
                for (int k = 0; k < NSTR; k++) send_expect(8'(k * 7 + 3));
            end
            begin
                n = 0;
                while (!irq && n < 4 * BITC * 10) begin @(negedge clk); n++; end
                checks++;
                if (irq !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_first_push actual=%b required=1", irq);
                end else begin
                    base = cyc;
                    // Frames are exactly 10 bit times apart, so each read lands on the next push.
                    for (int k = 1; k < NSTR; k++) begin
                        while (cyc < base + 10 * BITC * k - 1) @(negedge clk);
                        bus(1'b0, 1'b0, '0, 0, rd);
                        ex = {24'b0, exp_q.pop_front()};
                        checks++; if (rd !== ex) begin failures++; $display("FAIL stream_data%0d actual=%h required=%h", k, rd, ex); end
                        bus(1'b0, 1'b1, '0, 0, rd);
                        checks++; if (rd[16:8] !== 9'd1 || rd[2] !== 1'b0) begin failures++; $display("FAIL stream_status%0d actual=%h required=count 1 no ovr", k, rd); end
                    end
                end
            end
        join
        repeat (20) @(negedge clk);
        bus(1'b0, 1'b0, '0, 0, rd);
        ex = (exp_q.size() != 0) ? {24'b0, exp_q.pop_front()} : 32'hFFFF_FFFF;
        checks++; if (rd !== ex) begin failures++; $display("FAIL stream_last actual=%h required=%h", rd, ex); end
        bus(1'b0, 1'b1, '0, 0, rd);
        checks++; if (rd !== exp_status()) begin failures++; $display("FAIL stream_status_end actual=%h required=%h", rd, exp_status()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, ex;
        send_expect(8'h42);
        repeat (20) @(negedge clk);
        bus(1'b0, 1'b1, '0, 0, rd);
        rx = 1'b0; repeat (5 * BITC + BITC / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL midrst_rdata actual=%h required=0", rdata); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL midrst_ready actual=%b required=0", ready); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midrst_irq actual=%b required=0", irq); end
        @(negedge clk);
        rst_n = 1'b1; rx = 1'b1;
        exp_q.delete(); exp_ovr = 1'b0; exp_ferr = 1'b0;
        repeat (2 * BITC) @(negedge clk);
        bus(1'b0, 1'b1, '0, 0, rd);
        checks++; if (rd !== exp_status()) begin failures++; $display("FAIL midrst_status actual=%h required=%h", rd, exp_status()); end
        send_expect(8'h81);
        repeat (20) @(negedge clk);
        bus(1'b0, 1'b0, '0, 0, rd);
        ex = {24'b0, exp_q.pop_front()};
        checks++; if (rd !== ex) begin failures++; $display("FAIL midrst_data actual=%h required=%h", rd, ex); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_glitch();
        test_ferr();
        test_overflow();
        test_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
